// File: rtl/aes_pkg.sv
// ============================================================================
// Module   : aes_pkg
// Purpose  : Shared AES constants, key-schedule state encoding and rotate amount.
// Revision : 1.0
// ============================================================================
`default_nettype none

package aes_pkg;

  localparam int NR     = 10;
  localparam int NK     = 4;
  localparam int RND_W  = 4;
  localparam int ROT_SH = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_DONE   = 2'd2
  } ks_state_t;

endpackage

`default_nettype wire

// File: rtl/aes_sub_word.sv
// ============================================================================
// Module   : aes_sub_word
// Purpose  : Four parallel combinational AES S-box lookups on a 32-bit word.
// Revision : 1.0
// ============================================================================
`default_nettype none

module aes_sub_word (
  input  logic [31:0] in_word,
  output logic [31:0] out_word
);

  // Byte x lives at bits [(255-x)*8 +: 8], i.e. at offset {~x, 3'b000}.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  for (genvar i = 0; i < 4; i++) begin : g_byte
    assign out_word[8*i +: 8] = SBOX[{~in_word[8*i +: 8], 3'b000} +: 8];
  end

endmodule

`default_nettype wire

// File: rtl/rcon.sv
// ============================================================================
// Module   : rcon
// Purpose  : AES round constant word {rc,24'h0} for count 1..10; zero otherwise.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rcon (
  input  logic [7:0]  count,
  output logic [31:0] word
);

  logic [7:0] w_rc;

  always_comb begin
    w_rc = 8'h00;
    case (count)
      8'd1:    w_rc = 8'h01;
      8'd2:    w_rc = 8'h02;
      8'd3:    w_rc = 8'h04;
      8'd4:    w_rc = 8'h08;
      8'd5:    w_rc = 8'h10;
      8'd6:    w_rc = 8'h20;
      8'd7:    w_rc = 8'h40;
      8'd8:    w_rc = 8'h80;
      8'd9:    w_rc = 8'h1b;
      8'd10:   w_rc = 8'h36;
      default: w_rc = 8'h00;
    endcase
  end

  assign word = {w_rc, 24'h000000};

endmodule

`default_nettype wire

// File: rtl/aes_key_expand.sv
// ============================================================================
// Module   : aes_key_expand
// Purpose  : Iterative AES-128 key schedule, one round key per handshake.
//            Optional round-key store enabled by AES_KEY_STORE_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module aes_key_expand
  import aes_pkg::*;
#(
  parameter int NR    = aes_pkg::NR,
  parameter int RND_W = aes_pkg::RND_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [127:0]     key_in,
  output logic             rk_valid,
  input  logic             rk_ready,
  output logic [127:0]     rk,
  output logic [RND_W-1:0] rk_round,
  output logic             busy,
  output logic             done
`ifdef AES_KEY_STORE_EN
  ,
  input  logic [RND_W-1:0] rd_addr,
  output logic [127:0]     rd_key
`endif
);

  ks_state_t   r_state;
  logic [7:0]  w_count;
  logic [31:0] w_rcon;
  logic [31:0] w_rot;
  logic [31:0] w_sub;
  logic [31:0] w_t;
  logic [31:0] w_n0, w_n1, w_n2, w_n3;
  logic        w_hs;

  assign w_count = {{(8-RND_W){1'b0}}, rk_round} + 8'd1;

  rcon u_rcon (
    .count (w_count),
    .word  (w_rcon)
  );

  assign w_rot = (rk[31:0] << ROT_SH) | (rk[31:0] >> (32 - ROT_SH));

  aes_sub_word u_sub_word (
    .in_word  (w_rot),
    .out_word (w_sub)
  );

  assign w_t  = w_sub ^ w_rcon;
  assign w_n0 = rk[127:96] ^ w_t;
  assign w_n1 = rk[95:64]  ^ w_n0;
  assign w_n2 = rk[63:32]  ^ w_n1;
  assign w_n3 = rk[31:0]   ^ w_n2;

  assign w_hs = (r_state == ST_EXPAND) && rk_valid && rk_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      rk_valid <= 1'b0;
      rk       <= '0;
      rk_round <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            rk       <= key_in;
            rk_round <= '0;
            rk_valid <= 1'b1;
            busy     <= 1'b1;
            r_state  <= ST_EXPAND;
          end
        end
        ST_EXPAND: begin
          if (w_hs) begin
            if (rk_round == RND_W'(NR)) begin
              rk_valid <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
              r_state  <= ST_DONE;
            end else begin
              rk       <= {w_n0, w_n1, w_n2, w_n3};
              rk_round <= rk_round + 1'b1;
            end
          end
        end
        ST_DONE: begin
          done    <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef AES_KEY_STORE_EN
  logic [127:0] r_store [NR+1];

  // Every accepted key is kept so the inverse cipher can walk rounds backwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i <= NR; i++) r_store[i] <= '0;
    end else if (w_hs) begin
      r_store[rk_round] <= rk;
    end
  end

  assign rd_key = (rd_addr <= RND_W'(NR)) ? r_store[rd_addr] : '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_aes_key_expand.sv
// ============================================================================
// Module   : tb_aes_key_expand
// Purpose  : Self-checking bench for aes_key_expand (AES_KEY_STORE_EN aware).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_aes_key_expand;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] key_in;
  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] rk;
  logic [3:0]   rk_round;
  logic         busy;
  logic         done;
`ifdef AES_KEY_STORE_EN
  logic [3:0]   rd_addr;
  logic [127:0] rd_key;
`endif

  always #5 clk = ~clk;

  aes_key_expand dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .key_in   (key_in),
    .rk_valid (rk_valid),
    .rk_ready (rk_ready),
    .rk       (rk),
    .rk_round (rk_round),
    .busy     (busy),
    .done     (done)
`ifdef AES_KEY_STORE_EN
    ,
    .rd_addr  (rd_addr),
    .rd_key   (rd_key)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]   sb [256];
  logic [127:0] exp_keys [11];
  logic [127:0] cap [11];

  typedef struct {
    logic [127:0] key;
    int           rnd;
    logic [127:0] want;
  } vec_t;

  vec_t tbl [5];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, want);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  // S-box from its definition: GF(2^8) inverse followed by the affine map.
  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic model_expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) exp_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic run_keys(input logic [127:0] key, input int stall_at, input int stall_n,
                          input int inj_at, input int abort_at, input bit start_in_done);
    model_expand(key);
    @(negedge clk);
    key_in = key;
    start  = 1'b1;
    rk_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int r = 0; r <= 10; r++) begin
      cap[r] = rk;
      chk($sformatf("valid r%0d", r), 128'(rk_valid), 128'(1));
      chk($sformatf("round r%0d", r), 128'(rk_round), 128'(r));
      chk($sformatf("key r%0d", r), rk, exp_keys[r]);
      chk($sformatf("busy r%0d", r), 128'(busy), 128'(1));
      chk($sformatf("done_low r%0d", r), 128'(done), 128'(0));
      if (r == abort_at) return;
      if (r == stall_at) begin
        rk_ready = 1'b0;
        for (int s = 0; s < stall_n; s++) begin
          @(negedge clk);
          chk("stall_round", 128'(rk_round), 128'(r));
          chk("stall_key", rk, exp_keys[r]);
          chk("stall_valid", 128'(rk_valid), 128'(1));
        end
        rk_ready = 1'b1;
      end
      if (r == inj_at) begin
        start  = 1'b1;
        key_in = key ^ 128'h5a5a5a5a_a5a5a5a5_0f0f0f0f_f0f0f0f0;
      end
      @(negedge clk);
      start = 1'b0;
    end
    chk("end_valid", 128'(rk_valid), 128'(0));
    chk("end_done", 128'(done), 128'(1));
    chk("end_busy", 128'(busy), 128'(0));
    chk("end_round", 128'(rk_round), 128'(10));
    chk("end_key", rk, exp_keys[10]);
    if (start_in_done) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("done_pulse_end", 128'(done), 128'(0));
    chk("hold_round", 128'(rk_round), 128'(10));
    chk("hold_key", rk, exp_keys[10]);
    chk("idle_valid", 128'(rk_valid), 128'(0));
    @(negedge clk);
    chk("idle_valid2", 128'(rk_valid), 128'(0));
    chk("idle_busy2", 128'(busy), 128'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] fips_key;
    logic [127:0] k;
    fips_key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    tbl[0] = '{fips_key, 0, fips_key};
    tbl[1] = '{fips_key, 1, 128'ha0fafe1788542cb123a339392a6c7605};
    tbl[2] = '{fips_key, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    tbl[3] = '{128'h0, 1, 128'h62636363626363636263636362636363};
    tbl[4] = '{128'h0, 10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e};

    rst = 1'b1; start = 1'b0; rk_ready = 1'b0; key_in = '0;
`ifdef AES_KEY_STORE_EN
    rd_addr = '0;
`endif
    build_sbox();
    repeat (3) @(negedge clk);
    chk("rst_valid", 128'(rk_valid), 128'(0));
    chk("rst_rk", rk, 128'(0));
    chk("rst_round", 128'(rk_round), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      run_keys(tbl[i].key, -1, 0, -1, -1, 1'b0);
      chk($sformatf("vec%0d r%0d", i, tbl[i].rnd), cap[tbl[i].rnd], tbl[i].want);
    end

`ifdef AES_KEY_STORE_EN
    run_keys(fips_key, -1, 0, -1, -1, 1'b0);
    rd_addr = 4'd1;  #1 chk("store_a1", rd_key, 128'ha0fafe1788542cb123a339392a6c7605);
    rd_addr = 4'd10; #1 chk("store_a10", rd_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    rd_addr = 4'd0;  #1 chk("store_a0", rd_key, fips_key);
    rd_addr = 4'd15; #1 chk("store_a15", rd_key, 128'h0);
`endif

    // Stall at round 3, then a stray start at round 5 with a different key.
    run_keys(fips_key, 3, 5, -1, -1, 1'b0);
    chk("stall_final", cap[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    run_keys(fips_key, -1, 0, 5, -1, 1'b1);
    chk("inject_final", cap[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // Reset in the middle of expansion.
    run_keys(fips_key, -1, 0, -1, 6, 1'b0);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 128'(rk_valid), 128'(0));
    chk("mid_rst_rk", rk, 128'(0));
    chk("mid_rst_round", 128'(rk_round), 128'(0));
    chk("mid_rst_busy", 128'(busy), 128'(0));
    chk("mid_rst_done", 128'(done), 128'(0));
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("post_rst_done", 128'(done), 128'(0));
      chk("post_rst_valid", 128'(rk_valid), 128'(0));
    end
`ifdef AES_KEY_STORE_EN
    rd_addr = 4'd1; #1 chk("store_cleared", rd_key, 128'h0);
`endif
    run_keys(128'h000102030405060708090a0b0c0d0e0f, -1, 0, -1, -1, 1'b0);

    for (int it = 0; it < 16; it++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      run_keys(k, int'($urandom_range(0, 10)), int'($urandom_range(0, 4)),
               int'($urandom_range(0, 12)), -1, 1'($urandom_range(0, 1)));
`ifdef AES_KEY_STORE_EN
      for (int a = 0; a < 11; a++) begin
        rd_addr = 4'(a);
        #1 chk($sformatf("store_rand a%0d", a), rd_key, exp_keys[a]);
      end
`endif
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
